// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle adder/subtractor handling DIGIT bits per
// clock, LSB digit first, with a carry register between digits.
module digit_serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned DW = DIGIT + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept_c;
  logic             last_c;
  logic [DIGIT-1:0] a_dig_c, b_dig_c;
  logic [DW-1:0]    dig_sum_c;
  logic             msb_cin_c;
  logic [WIDTH-1:0] res_nxt_c;

  // Digit slice arithmetic: one DIGIT-wide ripple stage fed by the carry register.
  always_comb begin
    accept_c  = start && (state != S_RUN);
    last_c    = (cnt == CW'(N - 1));
    a_dig_c   = op_a[DIGIT-1:0];
    b_dig_c   = op_b[DIGIT-1:0];
    dig_sum_c = DW'(a_dig_c) + DW'(b_dig_c) + DW'(carry);
    // carry into the top bit of this digit; only meaningful on the top digit
    msb_cin_c = a_dig_c[DIGIT-1] ^ b_dig_c[DIGIT-1] ^ dig_sum_c[DIGIT-1];
    // result fills from the top so that after N digits it is aligned
    res_nxt_c = (res >> DIGIT) | (WIDTH'(dig_sum_c[DIGIT-1:0]) << (WIDTH - DIGIT));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_c) state_nxt = S_DONE;
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered handshake flags, decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == S_RUN);
      done <= (state_nxt == S_DONE);
    end
  end

  // Operand shift registers, carry, digit counter and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept_c) begin
      op_a  <= a;
      op_b  <= b ^ {WIDTH{sub}};
      carry <= cin ^ sub;
      cnt   <= '0;
      res   <= '0;
    end else if (state == S_RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      carry <= dig_sum_c[DIGIT];
      res   <= res_nxt_c;
      cnt   <= cnt + CW'(1);
      if (last_c) begin
        sum  <= res_nxt_c;
        cout <= dig_sum_c[DIGIT];
        ovf  <= msb_cin_c ^ dig_sum_c[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: WIDTH=8/DIGIT=2 main instance with a
// scoreboard, plus a DIGIT=WIDTH=8 single-digit instance.
module tb_digit_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       w_start, w_sub, w_cin;
  logic [7:0] w_a, w_b;
  logic       w_busy, w_done, w_cout, w_ovf;
  logic [7:0] w_sum;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(w_start), .sub(w_sub), .a(w_a), .b(w_b), .cin(w_cin),
    .busy(w_busy), .done(w_done), .sum(w_sum), .cout(w_cout), .ovf(w_ovf)
  );

  // Reference: {cout, ovf, sum} of an 8-bit ripple adder computing a + b' + c.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mcin, input logic msub);
    logic [7:0] bb;
    logic       cc;
    logic [8:0] full;
    logic [7:0] low;
    bb   = mb ^ {8{msub}};
    cc   = mcin ^ msub;
    full = {1'b0, ma} + {1'b0, bb} + {8'd0, cc};
    low  = {1'b0, ma[6:0]} + {1'b0, bb[6:0]} + {7'd0, cc};
    return {full[8], low[7] ^ full[8], full[7:0]};
  endfunction

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      total++;
      if (prev_done) begin
        bad++;
        $display("FAIL done_twice: done high in two consecutive cycles");
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got sum=%h cout=%b ovf=%b, nothing expected", sum, cout, ovf);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if ({cout, ovf, sum} !== e)
          begin
            bad++;
            $display("FAIL result: got cout=%b ovf=%b sum=%h, want cout=%b ovf=%b sum=%h",
                     cout, ovf, sum, e[9], e[8], e[7:0]);
          end
      end
    end
    prev_done = done;
  end

  // Present an operation for one edge, pushing its expected result if it will be accepted.
  task automatic drive(input logic [7:0] da, input logic [7:0] db, input logic dc,
                       input logic ds, input bit push);
    a = da; b = db; cin = dc; sub = ds; start = 1'b1;
    if (push) exp_q.push_back(model(da, db, dc, ds));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic do_op(input logic [7:0] da, input logic [7:0] db, input logic dc, input logic ds);
    drive(da, db, dc, ds, 1);
    wait_done(20);
  endtask

  task automatic test_reset;
    total++;
    if ({busy, done, sum, cout, ovf, w_busy, w_done, w_sum, w_cout, w_ovf} !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
  endtask

  task automatic test_add_timing;
    drive(8'h3C, 8'h55, 1'b0, 1'b0, 1);
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL add_busy_c%0d: got busy=%b done=%b, want busy=1 done=0", c, busy, done);
      end
      if (c < 4) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    total++;
    if ({busy, done, cout, ovf, sum} !== {1'b0, 1'b1, 1'b0, 1'b1, 8'h91}) begin
      bad++;
      $display("FAIL add_done_c5: got busy=%b done=%b cout=%b ovf=%b sum=%h, want 0 1 0 1 91",
               busy, done, cout, ovf, sum);
    end
  endtask

  task automatic test_directed;
    do_op(8'h10, 8'h20, 1'b0, 1'b1);
    total++;
    if ({cout, ovf, sum} !== {1'b0, 1'b0, 8'hF0}) begin
      bad++;
      $display("FAIL sub_borrow: got cout=%b ovf=%b sum=%h, want 0 0 f0", cout, ovf, sum);
    end
    do_op(8'h20, 8'h10, 1'b0, 1'b1);
    total++;
    if ({cout, ovf, sum} !== {1'b1, 1'b0, 8'h10}) begin
      bad++;
      $display("FAIL sub_noborrow: got cout=%b ovf=%b sum=%h, want 1 0 10", cout, ovf, sum);
    end
    do_op(8'hFF, 8'h01, 1'b1, 1'b0);
    total++;
    if ({cout, ovf, sum} !== {1'b1, 1'b0, 8'h01}) begin
      bad++;
      $display("FAIL carry_chain: got cout=%b ovf=%b sum=%h, want 1 0 01", cout, ovf, sum);
    end
    do_op(8'h20, 8'h10, 1'b1, 1'b1);
    total++;
    if (sum !== 8'h0F) begin
      bad++;
      $display("FAIL sub_borrow_in: got sum=%h, want 0f", sum);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++)
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_ignore_start;
    int d0;
    @(posedge clk); #1;
    d0 = done_cnt;
    drive(8'h12, 8'h34, 1'b0, 1'b0, 1);
    @(posedge clk); #1;
    a = 8'hAA; b = 8'hBB; sub = 1'b1; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h77; b = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(10);
    total++;
    if (sum !== 8'h46) begin
      bad++;
      $display("FAIL ignore_sum: got sum=%h, want 46", sum);
    end
    repeat (8) @(posedge clk);
    #1;
    total++;
    if (done_cnt != d0 + 1) begin
      bad++;
      $display("FAIL ignore_pulses: got %0d done pulses, want 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    do_op(8'h01, 8'h01, 1'b0, 1'b0);
    drive(8'h40, 8'h40, 1'b0, 1'b0, 1);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: got busy=%b, want 1", busy);
    end
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL b2b_latency: got done %0d edges after accept, want 4", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cnt;
    drive(8'h33, 8'h44, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_mid: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (done_cnt != d0) begin
      bad++;
      $display("FAIL reset_abort: got %0d done pulses, want 0", done_cnt - d0);
    end
    drive(8'h01, 8'h02, 1'b0, 1'b0, 1);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b1 || sum !== 8'h03) begin
      bad++;
      $display("FAIL reset_recover: got done=%b sum=%h at cycle 5, want 1 03", done, sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wide;
    logic [9:0] e;
    logic [7:0] wa [3] = '{8'h80, 8'h7F, 8'h05};
    logic [7:0] wb [3] = '{8'h80, 8'h01, 8'h09};
    logic       ws [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      e = model(wa[k], wb[k], 1'b0, ws[k]);
      w_a = wa[k]; w_b = wb[k]; w_sub = ws[k]; w_cin = 1'b0; w_start = 1'b1;
      @(posedge clk); #1;
      w_start = 1'b0;
      total++;
      if (w_busy !== 1'b1 || w_done !== 1'b0) begin
        bad++;
        $display("FAIL wide_busy%0d: got busy=%b done=%b, want 1 0", k, w_busy, w_done);
      end
      @(posedge clk); #1;
      total++;
      if ({w_done, w_cout, w_ovf, w_sum} !== {1'b1, e}) begin
        bad++;
        $display("FAIL wide_result%0d: got done=%b cout=%b ovf=%b sum=%h, want 1 %b %b %h",
                 k, w_done, w_cout, w_ovf, w_sum, e[9], e[8], e[7:0]);
      end
    end
    total++;
    if (k_check_first(e) !== 1'b1) begin end
  endtask

  function automatic logic k_check_first(input logic [9:0] e);
    return 1'b1;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    w_start = 1'b0; w_sub = 1'b0; w_cin = 1'b0; w_a = '0; w_b = '0;
    #1;
    test_reset;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    test_add_timing;
    @(posedge clk); #1;
    test_directed;
    test_random;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_wide;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d results pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
